// File: rtl/dealer_turn_sequencer.sv
// Dealer turn sequencer: clears the dealer hand, pulls cards from the deck stage and stops on
// stand, bust or 5-card Charlie. Define DEALER_HIT_SOFT17_EN to make the dealer hit soft 17.
module dealer_turn_sequencer #(
    parameter int unsigned STAND_AT  = 17,
    parameter int unsigned BUST_OVER = 21,
    parameter int unsigned MAX_CARDS = 5,
    localparam int unsigned CARD_W   = 4,
    localparam int unsigned SUM_W    = 5,
    localparam int unsigned CNT_W    = 3
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_cardReq,
    input  logic              i_cardValid,
    input  logic [CARD_W-1:0] i_card,
    output logic              o_handClear,
    output logic              o_addNewCard,
    output logic [CARD_W-1:0] o_newCard,
    input  logic [SUM_W-1:0]  i_handSum,
    input  logic [CNT_W-1:0]  i_numCards,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_stood,
    output logic              o_bust,
    output logic              o_charlie,
    output logic [SUM_W-1:0]  o_finalSum
);

    localparam int unsigned EXT_W        = SUM_W + 1;
    localparam int unsigned SOFT_HIT_SUM = 17;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        REQ   = 3'd2,
        ADD   = 3'd3,
        EVAL  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [CARD_W-1:0]  card_q;
    logic [CARD_W-1:0]  card_d;
    logic               stood_d;
    logic               bust_d;
    logic               charlie_d;
    logic [SUM_W-1:0]   final_sum_d;
    logic               card_req_d;
    logic               hand_clear_d;
    logic               add_card_d;
    logic [CARD_W-1:0]  new_card_d;
    logic               busy_d;
    logic               done_d;

    logic               over_bust;
    logic               at_charlie;
    logic               in_deal;
    logic               at_stand;
    logic               hit_soft;
    logic               transfer;

    assign over_bust  = i_handSum > SUM_W'(BUST_OVER);
    assign at_charlie = i_numCards == CNT_W'(MAX_CARDS);
    assign in_deal    = i_numCards < CNT_W'(2);
    assign at_stand   = i_handSum >= SUM_W'(STAND_AT);
    assign transfer   = o_cardReq && i_cardValid;

`ifdef DEALER_HIT_SOFT17_EN
    // Soft flag: an ace the hand controller counted as 11 (it never demotes it later).
    logic soft_q;
    logic ace_as_eleven;

    assign ace_as_eleven = (card_q == CARD_W'(1)) &&
                           (EXT_W'(i_handSum) + EXT_W'(11) <= EXT_W'(BUST_OVER));
    assign hit_soft      = soft_q && (i_handSum == SUM_W'(SOFT_HIT_SUM));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            soft_q <= 1'b0;
        end else if (i_abort || state == CLEAR) begin
            soft_q <= 1'b0;
        end else if (state == ADD && ace_as_eleven) begin
            soft_q <= 1'b1;
        end
    end
`else
    assign hit_soft = 1'b0;
`endif

    // Next-state and next-output decode; strobes come from the next state so they register cleanly.
    always_comb begin
        state_d     = state;
        card_d      = card_q;
        stood_d     = o_stood;
        bust_d      = o_bust;
        charlie_d   = o_charlie;
        final_sum_d = o_finalSum;

        if (i_abort && state != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state_d     = CLEAR;
                        stood_d     = 1'b0;
                        bust_d      = 1'b0;
                        charlie_d   = 1'b0;
                        final_sum_d = '0;
                    end
                end
                CLEAR: state_d = REQ;
                REQ: begin
                    if (transfer) begin
                        card_d  = i_card;
                        state_d = ADD;
                    end
                end
                ADD: state_d = EVAL;
                EVAL: begin
                    if (over_bust) begin
                        bust_d      = 1'b1;
                        final_sum_d = i_handSum;
                        state_d     = DONE;
                    end else if (at_charlie) begin
                        charlie_d   = 1'b1;
                        final_sum_d = i_handSum;
                        state_d     = DONE;
                    end else if (in_deal) begin
                        state_d = REQ;
                    end else if (at_stand && !hit_soft) begin
                        stood_d     = 1'b1;
                        final_sum_d = i_handSum;
                        state_d     = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        hand_clear_d = state_d == CLEAR;
        card_req_d   = state_d == REQ;
        add_card_d   = state_d == ADD;
        new_card_d   = (state_d == ADD) ? card_d : '0;
        done_d       = state_d == DONE;
        busy_d       = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            card_q       <= '0;
            o_cardReq    <= 1'b0;
            o_handClear  <= 1'b0;
            o_addNewCard <= 1'b0;
            o_newCard    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_stood      <= 1'b0;
            o_bust       <= 1'b0;
            o_charlie    <= 1'b0;
            o_finalSum   <= '0;
        end else begin
            state        <= state_d;
            card_q       <= card_d;
            o_cardReq    <= card_req_d;
            o_handClear  <= hand_clear_d;
            o_addNewCard <= add_card_d;
            o_newCard    <= new_card_d;
            o_busy       <= busy_d;
            o_done       <= done_d;
            o_stood      <= stood_d;
            o_bust       <= bust_d;
            o_charlie    <= charlie_d;
            o_finalSum   <= final_sum_d;
        end
    end

endmodule

// File: tb/tb_dealer_turn_sequencer.sv
// Bench for dealer_turn_sequencer: a deck driver and a dealer-hand model around the DUT,
// with expected outcomes queued per turn and compared when o_done pulses.
module tb_dealer_turn_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_start;
    logic       i_abort;
    logic       o_cardReq;
    logic       i_cardValid;
    logic [3:0] i_card;
    logic       o_handClear;
    logic       o_addNewCard;
    logic [3:0] o_newCard;
    logic [4:0] i_handSum;
    logic [2:0] i_numCards;
    logic       o_busy;
    logic       o_done;
    logic       o_stood;
    logic       o_bust;
    logic       o_charlie;
    logic [4:0] o_finalSum;

    typedef struct {
        logic       stood;
        logic       bust;
        logic       charlie;
        logic [4:0] sum;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    dealer_turn_sequencer dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .o_cardReq    (o_cardReq),
        .i_cardValid  (i_cardValid),
        .i_card       (i_card),
        .o_handClear  (o_handClear),
        .o_addNewCard (o_addNewCard),
        .o_newCard    (o_newCard),
        .i_handSum    (i_handSum),
        .i_numCards   (i_numCards),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_stood      (o_stood),
        .o_bust       (o_bust),
        .o_charlie    (o_charlie),
        .o_finalSum   (o_finalSum)
    );

    always #5 i_clk = ~i_clk;

    // Dealer hand controller model: an ace counts 11 when it fits, and is never demoted.
    function automatic logic [4:0] add_card(input logic [4:0] s, input logic [3:0] c);
        int t;
        t = int'(s);
        if (c == 4'd1 && t + 11 <= 21) t = t + 11;
        else t = t + int'(c);
        if (t > 31) t = 31;
        return 5'(t);
    endfunction

    logic [4:0] hand_sum;
    logic [2:0] hand_n;
    assign i_handSum  = hand_sum;
    assign i_numCards = hand_n;

    always @(posedge i_clk) begin
        if (!i_reset_n || o_handClear) begin
            hand_sum <= 5'd0;
            hand_n   <= 3'd0;
        end else if (o_addNewCard) begin
            hand_sum <= add_card(hand_sum, o_newCard);
            hand_n   <= hand_n + 3'd1;
        end
    end

    task automatic expect_outcome(input logic s, input logic b, input logic c, input logic [4:0] sum);
        exp_t e;
        e.stood = s; e.bust = b; e.charlie = c; e.sum = sum;
        exp_q.push_back(e);
    endtask

    // One full turn: starts, serves cards after an optional stall, checks the outcome on o_done.
    task automatic run_turn(input string name, input int cards[8], input int n_cards,
                            input int stall_n, input bit poke_start,
                            output int cycles, output int adds, output int clears);
        int   idx = 0;
        int   stall = stall_n;
        int   extra = 0;
        bit   done = 1'b0;
        bit   poke = poke_start;
        exp_t e;
        cycles = 0; adds = 0; clears = 0;
        @(negedge i_clk);
        i_start = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (o_busy || o_done) cycles++;
            if (o_addNewCard) adds++;
            if (o_handClear) clears++;
            if (poke && o_addNewCard) begin
                i_start = 1'b1;
                poke = 1'b0;
            end
            if (o_done) begin
                done = 1'b1;
                i_cardValid = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s scoreboard: o_done with no expected outcome queued", name);
                end else begin
                    e = exp_q.pop_front();
                    checks += 3;
                    if ({o_stood, o_bust, o_charlie} !== {e.stood, e.bust, e.charlie}) begin
                        errors++;
                        $display("FAIL %s flags: got stood/bust/charlie=%b%b%b want %b%b%b",
                                 name, o_stood, o_bust, o_charlie, e.stood, e.bust, e.charlie);
                    end
                    if (o_finalSum !== e.sum) begin
                        errors++;
                        $display("FAIL %s final_sum: got %0d want %0d", name, o_finalSum, e.sum);
                    end
                    if (o_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL %s busy_in_done: got %b want 0", name, o_busy);
                    end
                end
            end else if (o_cardReq) begin
                if (stall > 0) begin
                    i_cardValid = 1'b0;
                    stall--;
                end else if (idx < n_cards) begin
                    i_cardValid = 1'b1;
                    i_card = 4'(cards[idx]);
                    idx++;
                end else begin
                    i_cardValid = 1'b0;
                    extra++;
                end
            end else begin
                i_cardValid = 1'b0;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: o_done not seen within 200 cycles", name);
        end
        checks++;
        if (extra !== 0 || idx !== n_cards) begin
            errors++;
            $display("FAIL %s card_requests: used %0d of %0d cards, %0d extra requests",
                     name, idx, n_cards, extra);
        end
        @(negedge i_clk);
        checks += 2;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: after done got done=%b busy=%b want 0 0", name, o_done, o_busy);
        end
        if (done && o_finalSum !== e.sum) begin
            errors++;
            $display("FAIL %s sum_hold: got %0d want %0d", name, o_finalSum, e.sum);
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!o_cardReq && n < 20) begin
            @(negedge i_clk);
            i_start = 1'b0;
            n++;
        end
        checks++;
        if (!o_cardReq) begin
            errors++;
            $display("FAIL %s wait_req: o_cardReq never rose, got %b want 1", name, o_cardReq);
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_start = 1'b1; i_abort = 1'b1; i_cardValid = 1'b1; i_card = 4'd10;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_cardReq, o_handClear, o_addNewCard, o_newCard, o_busy, o_done,
             o_stood, o_bust, o_charlie, o_finalSum} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b clr=%b add=%b busy=%b done=%b sum=%0d want all 0",
                     o_cardReq, o_handClear, o_addNewCard, o_busy, o_done, o_finalSum);
        end
        i_reset_n = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_cardValid = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_handClear !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b clr=%b want 0 0", o_busy, o_handClear);
        end
    endtask

    task automatic test_stand();
        int cyc, adds, clr;
        expect_outcome(1'b1, 1'b0, 1'b0, 5'd17);
        run_turn("stand", '{10, 7, 0, 0, 0, 0, 0, 0}, 2, 0, 1'b0, cyc, adds, clr);
        checks += 3;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL stand_cycles: got %0d want 8", cyc);
        end
        if (adds !== 2) begin
            errors++;
            $display("FAIL stand_adds: got %0d want 2", adds);
        end
        if (clr !== 1) begin
            errors++;
            $display("FAIL stand_clears: got %0d want 1", clr);
        end
    endtask

    task automatic test_bust();
        int cyc, adds, clr;
        expect_outcome(1'b0, 1'b1, 1'b0, 5'd25);
        run_turn("bust", '{10, 6, 9, 0, 0, 0, 0, 0}, 3, 2, 1'b0, cyc, adds, clr);
        checks++;
        if (adds !== 3) begin
            errors++;
            $display("FAIL bust_adds: got %0d want 3", adds);
        end
    endtask

    task automatic test_charlie();
        int cyc, adds, clr;
        expect_outcome(1'b0, 1'b0, 1'b1, 5'd12);
        run_turn("charlie", '{2, 2, 3, 2, 3, 0, 0, 0}, 5, 0, 1'b0, cyc, adds, clr);
        checks++;
        if (adds !== 5) begin
            errors++;
            $display("FAIL charlie_adds: got %0d want 5", adds);
        end
    endtask

    task automatic test_soft17();
        int cyc, adds, clr;
`ifdef DEALER_HIT_SOFT17_EN
        expect_outcome(1'b1, 1'b0, 1'b0, 5'd21);
        run_turn("soft17", '{1, 6, 4, 0, 0, 0, 0, 0}, 3, 0, 1'b0, cyc, adds, clr);
`else
        expect_outcome(1'b1, 1'b0, 1'b0, 5'd17);
        run_turn("soft17", '{1, 6, 0, 0, 0, 0, 0, 0}, 2, 0, 1'b0, cyc, adds, clr);
`endif
    endtask

    task automatic test_busy_start();
        int cyc, adds, clr;
        expect_outcome(1'b1, 1'b0, 1'b0, 5'd19);
        run_turn("busy_start", '{9, 10, 0, 0, 0, 0, 0, 0}, 2, 1, 1'b1, cyc, adds, clr);
        checks += 2;
        if (clr !== 1) begin
            errors++;
            $display("FAIL busy_start_clears: got %0d want 1", clr);
        end
        if (adds !== 2) begin
            errors++;
            $display("FAIL busy_start_adds: got %0d want 2", adds);
        end
    endtask

    task automatic test_abort();
        int  cyc, adds, clr;
        bit  saw_done = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_req("abort");
        i_cardValid = 1'b0;
        repeat (5) @(negedge i_clk);
        checks++;
        if (o_cardReq !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_stall: got req=%b busy=%b want 1 1", o_cardReq, o_busy);
        end
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        checks++;
        if ({o_busy, o_cardReq, o_done, o_addNewCard} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_idle: got busy/req/done/add=%b%b%b%b want 0000",
                     o_busy, o_cardReq, o_done, o_addNewCard);
        end
        repeat (4) begin
            @(negedge i_clk);
            if (o_done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got o_done pulse want none");
        end
        expect_outcome(1'b1, 1'b0, 1'b0, 5'd20);
        run_turn("after_abort", '{10, 10, 0, 0, 0, 0, 0, 0}, 2, 0, 1'b0, cyc, adds, clr);
        checks++;
        if (clr !== 1) begin
            errors++;
            $display("FAIL after_abort_clears: got %0d want 1", clr);
        end
    endtask

    task automatic test_reset_mid_req();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_req("reset_mid_req");
        i_cardValid = 1'b1;
        i_card = 4'd5;
        i_reset_n = 1'b0;
        @(negedge i_clk);
        checks++;
        if ({o_busy, o_cardReq, o_addNewCard, o_handClear, o_done,
             o_stood, o_bust, o_charlie} !== 8'd0 || o_finalSum !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid_req: got busy/req/add/clr/done/s/b/c=%b%b%b%b%b%b%b%b sum=%0d want 0",
                     o_busy, o_cardReq, o_addNewCard, o_handClear, o_done,
                     o_stood, o_bust, o_charlie, o_finalSum);
        end
        i_reset_n = 1'b1;
        @(negedge i_clk);
        i_cardValid = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_addNewCard !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b add=%b want 0 0", o_busy, o_addNewCard);
        end
    endtask

    initial begin
        i_reset_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_cardValid = 1'b0; i_card = 4'd0;
        test_reset();
        test_stand();
        test_bust();
        test_charlie();
        test_soft17();
        test_busy_start();
        test_abort();
        test_reset_mid_req();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outcomes left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dealer_turn_sequencer.md
Name: dealer_turn_sequencer

Overview:
- Drives the dealer's hand through a full turn: clears the hand, pulls cards from the deck stage, and pushes each card into the dealer's hand controller.
- Evaluates the returned hand sum after every card and stops on stand, bust or 5-card Charlie.
- Sits between the deck/card-source stage (upstream) and the dealer hand controller (downstream).
- Reports the final outcome to the game-flow FSM.

Parameters:
- STAND_AT, 17: dealer stands when sum >= STAND_AT.
- BUST_OVER, 21: hand busts when sum > BUST_OVER.
- MAX_CARDS, 5: card count that triggers 5-card Charlie (non-bust).

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  synchronous active-low reset
- i_start  in  1  one-cycle pulse: begin dealer turn; ignored unless IDLE
- i_abort  in  1  abandon turn; return to IDLE without o_done
- o_cardReq  in/out: out  1  ready to accept a card from the deck stage
- i_cardValid  in  1  deck stage presents a card; transfer when o_cardReq && i_cardValid
- i_card  in  4  card value 1..10 (1 = ace)
- o_handClear  out  1  one-cycle active-high clear to the hand controller's reset input
- o_addNewCard  out  1  one-cycle strobe to the hand controller
- o_newCard  out  4  card value accompanying o_addNewCard
- i_handSum  in  5  hand controller sum
- i_numCards  in  3  hand controller card count
- o_busy  out  1  high in any state except IDLE and DONE
- o_done  out  1  one-cycle pulse when the outcome is valid
- o_stood  out  1  outcome: stood (held until next i_start)
- o_bust  out  1  outcome: bust (held)
- o_charlie  out  1  outcome: 5-card Charlie (held)
- o_finalSum  out  5  sum at end of turn (held)

Behaviour:
- Reset (i_reset_n=0 at posedge):
  - state=IDLE; all outputs 0; internal card latch and soft flag cleared.
  - Reset overrides i_start and i_abort.
- States and transitions:
  - IDLE: on i_start -> CLEAR. Outcome flags and o_finalSum are zeroed at this transition.
  - CLEAR: o_handClear=1 for exactly one cycle; soft flag cleared -> REQ.
  - REQ: o_cardReq=1. On transfer, latch i_card -> ADD. Stall indefinitely without transfer.
  - ADD: o_addNewCard=1 and o_newCard=latched card for exactly one cycle -> EVAL.
  - EVAL: i_handSum and i_numCards reflect the added card (hand controller registers on the ADD edge). Checks in priority order:
    1. sum > BUST_OVER -> o_bust.
    2. i_numCards == MAX_CARDS -> o_charlie.
    3. i_numCards < 2 -> REQ (initial two-card deal always completes).
    4. sum >= STAND_AT and not hitting soft 17 -> o_stood.
    5. Otherwise -> REQ.
    - On any outcome: latch o_finalSum=i_handSum, set that flag, -> DONE.
  - DONE: o_done=1 for one cycle -> IDLE. Flags and o_finalSum hold until the next i_start.
- Exactly one outcome flag is ever set per turn. Bust takes priority over Charlie when the fifth card busts.
- Soft flag:
  - Set when a card of 1 is added and the pre-add sum + 11 <= BUST_OVER, i.e. the hand controller counted the ace as 11.
  - Never cleared mid-turn; the hand controller never demotes an ace.
- i_start while not IDLE: ignored.
- i_abort (any non-IDLE state): next state IDLE. Strobes are 0 that cycle and no o_done is issued. A card presented in that same cycle is not accepted (o_cardReq forced 0).
- o_cardReq, o_addNewCard and o_handClear are registered outputs decoded from state, glitch-free.
- Minimum turn for 2 cards: CLEAR, then 2x(REQ, ADD, EVAL), then DONE = 8 cycles with zero deck stall.

Optional Feature:
- Macro: DEALER_HIT_SOFT17_EN.
- Defined: in EVAL, sum == 17 with soft flag set is treated as below threshold, so the dealer hits.
- Undefined: the dealer stands on any 17; soft-flag logic may be optimised away, and outcomes ignore it.

Test Plan:
- Reset mid-REQ with i_cardValid high -> next cycle: IDLE, o_cardReq=0, all flags 0, no strobe.
- Start; cards 10, 7 (sums 10, 17) -> stand after 2 cards; o_stood=1, o_finalSum=17; o_done one pulse; 8 cycles with zero stall.
- Start; cards 10, 6, 9 (sums 10, 16, 25) -> o_bust=1, o_finalSum=25; exactly 3 o_addNewCard pulses.
- Start; cards 2, 2, 3, 2, 3 (sum 12, 5 cards) -> o_charlie=1, o_finalSum=12; no 6th o_cardReq after the fifth transfer.
- Start; cards 1, 6 (soft 17) -> macro undefined: o_stood, sum 17. Macro defined: a third card is requested; supply 4 -> o_stood, sum 21.
- Deck stalls 5 cycles in REQ, then i_abort -> IDLE, no o_done; a following i_start pulses o_handClear and restarts cleanly. An i_start while busy has no effect.
